// File: rtl/scv_pkg.sv
// Shared types and helpers for the Super Cassette Vision cartridge path.
package scv_pkg;

  // Cartridge mapper types; MAPPER_AUTO asks the mapper to infer the type from image size.
  typedef enum logic [2:0] {
    MAPPER_AUTO          = 3'd0,
    MAPPER_ROM8K         = 3'd1,
    MAPPER_ROM16K        = 3'd2,
    MAPPER_ROM32K        = 3'd3,
    MAPPER_ROM32K_RAM8K  = 3'd4,
    MAPPER_ROM64K        = 3'd5,
    MAPPER_ROM128K       = 3'd6,
    MAPPER_ROM128K_RAM4K = 3'd7
  } mapper_t;

  // Cartridge mapper control states.
  typedef enum logic [1:0] {
    CART_IDLE     = 2'd0,
    CART_LOADING  = 2'd1,
    CART_CLASSIFY = 2'd2,
    CART_RUN      = 2'd3
  } cart_state_t;

  // Image size thresholds in bytes (inclusive upper bounds of each class).
  localparam logic [31:0] CART_8K  = 32'h0000_2000;
  localparam logic [31:0] CART_16K = 32'h0000_4000;
  localparam logic [31:0] CART_32K = 32'h0000_8000;
  localparam logic [31:0] CART_64K = 32'h0001_0000;

  // Smallest plain-ROM mapper that holds an image of the given byte size.
  function automatic mapper_t mapper_from_size(input logic [31:0] size);
    mapper_t m;
    if (size <= CART_8K) begin
      m = MAPPER_ROM8K;
    end else if (size <= CART_16K) begin
      m = MAPPER_ROM16K;
    end else if (size <= CART_32K) begin
      m = MAPPER_ROM32K;
    end else if (size <= CART_64K) begin
      m = MAPPER_ROM64K;
    end else begin
      m = MAPPER_ROM128K;
    end
    return m;
  endfunction

endpackage

// File: rtl/scv_cart_size_detect.sv
// Tracks the highest downloaded ROM address and classifies the image size.
module scv_cart_size_detect
  import scv_pkg::*;
#(
  parameter int ROM_AW = 17
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clear,
  input  logic              track,
  input  logic              load_wr,
  input  logic [ROM_AW-1:0] load_addr,
  input  logic              classify,
  output mapper_t           detected,
  output logic              done
);

  logic [ROM_AW-1:0] max_addr_r;
  logic [ROM_AW:0]   size_s;
  mapper_t           detected_r;
  mapper_t           class_s;

  // One extra bit on the size so a full-size image does not wrap to zero.
  assign size_s  = {1'b0, max_addr_r} + {{ROM_AW{1'b0}}, 1'b1};
  assign class_s = mapper_from_size(32'(size_s));

  // Highest-address tracker; a byte written on the entry cycle seeds the new load.
  always_ff @(posedge clk) begin
    if (res) begin
      max_addr_r <= '0;
    end else if (clear) begin
      max_addr_r <= load_wr ? load_addr : '0;
    end else if (track && load_wr && (load_addr > max_addr_r)) begin
      max_addr_r <= load_addr;
    end else begin
      max_addr_r <= max_addr_r;
    end
  end

  // Detected mapper is captured during classification and kept until the next one.
  always_ff @(posedge clk) begin
    if (res) begin
      detected_r <= MAPPER_ROM32K;
    end else if (classify) begin
      detected_r <= class_s;
    end else begin
      detected_r <= detected_r;
    end
  end

  // Look through to the fresh class during classification so the result is usable on the same edge.
  always_comb begin
    detected = detected_r;
    done     = classify;
    if (classify) begin
      detected = class_s;
    end else begin
      detected = detected_r;
    end
  end

endmodule

// File: rtl/scv_cart_mapper.sv
// Cartridge memory mapper: CPU 0x8000-0xFFFF to cartridge ROM/RAM addresses and strobes.
module scv_cart_mapper
  import scv_pkg::*;
#(
  parameter int ROM_AW = 17,
  parameter int RAM_AW = 13
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              CE,
  input  mapper_t           MAPPER_SEL,
  input  logic              LOAD_ACTIVE,
  input  logic              LOAD_WR,
  input  logic [ROM_AW-1:0] LOAD_ADDR,
  input  logic [15:0]       A,
  input  logic              RD,
  input  logic              WR,
  input  logic              BANK_WR,
  input  logic [1:0]        BANK_IN,
  output logic [ROM_AW-1:0] ROM_A,
  output logic              ROM_CE,
  output logic [RAM_AW-1:0] RAM_A,
  output logic              RAM_CE,
  output logic              RAM_WE,
  output mapper_t           MAPPER_ACT,
  output logic              READY
);

  cart_state_t       state_r, next_state_s;
  mapper_t           mapper_act_r, act_d_s, det_mapper_s;
  logic              det_done_s, ready_d_s, entry_s;
  logic [1:0]        bank_r;
  logic              rom_hit_s, ram_hit_s;
  logic [16:0]       rom_full_s;
  logic [12:0]       ram_full_s;
  logic [ROM_AW-1:0] rom_a_d_s, rom_a_r;
  logic [RAM_AW-1:0] ram_a_d_s, ram_a_r;
  logic              rom_ce_r, ram_ce_r, ram_we_r, ready_r;

  assign entry_s   = (next_state_s == CART_LOADING) && (state_r != CART_LOADING);
  assign ready_d_s = (next_state_s == CART_RUN);

  scv_cart_size_detect #(.ROM_AW(ROM_AW)) u_size_detect (
    .clk       (CLK),
    .res       (RES),
    .clear     (entry_s),
    .track     (state_r == CART_LOADING),
    .load_wr   (LOAD_WR),
    .load_addr (LOAD_ADDR),
    .classify  (state_r == CART_CLASSIFY),
    .detected  (det_mapper_s),
    .done      (det_done_s)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_r <= CART_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and the mapper that will be in effect after this edge.
  always_comb begin
    next_state_s = state_r;
    act_d_s      = mapper_act_r;
    case (state_r)
      CART_IDLE: begin
        if (LOAD_ACTIVE) begin
          next_state_s = CART_LOADING;
        end else if (MAPPER_SEL != MAPPER_AUTO) begin
          next_state_s = CART_RUN;
        end else begin
          next_state_s = CART_IDLE;
        end
      end
      CART_LOADING:  next_state_s = LOAD_ACTIVE ? CART_LOADING : CART_CLASSIFY;
      CART_CLASSIFY: next_state_s = det_done_s ? CART_RUN : CART_CLASSIFY;
      CART_RUN:      next_state_s = LOAD_ACTIVE ? CART_LOADING : CART_RUN;
      default:       next_state_s = CART_IDLE;
    endcase
    if (next_state_s == CART_RUN) begin
      act_d_s = (MAPPER_SEL != MAPPER_AUTO) ? MAPPER_SEL : det_mapper_s;
    end else begin
      act_d_s = mapper_act_r;
    end
  end

  // Bank register from port C, written on CPU clock enables only.
  always_ff @(posedge CLK) begin
    if (RES) begin
      bank_r <= 2'd0;
    end else if (CE && BANK_WR) begin
      bank_r <= BANK_IN;
    end else begin
      bank_r <= bank_r;
    end
  end

  // Address decode for the mapper that will be active when the registered outputs appear.
  always_comb begin
    rom_hit_s  = 1'b0;
    ram_hit_s  = 1'b0;
    rom_full_s = 17'd0;
    ram_full_s = 13'd0;
    if (A[15]) begin
      case (act_d_s)
        MAPPER_ROM8K:  begin rom_hit_s = 1'b1; rom_full_s = {4'd0, A[12:0]}; end
        MAPPER_ROM16K: begin rom_hit_s = 1'b1; rom_full_s = {3'd0, A[13:0]}; end
        MAPPER_ROM32K: begin rom_hit_s = 1'b1; rom_full_s = {2'd0, A[14:0]}; end
        MAPPER_ROM32K_RAM8K: begin
          if (A[14:13] == 2'b11) begin
            ram_hit_s  = 1'b1;
            ram_full_s = A[12:0];
          end else begin
            rom_hit_s  = 1'b1;
            rom_full_s = {2'd0, A[14:0]};
          end
        end
        MAPPER_ROM64K:  begin rom_hit_s = 1'b1; rom_full_s = {1'b0, bank_r[0], A[14:0]}; end
        MAPPER_ROM128K: begin rom_hit_s = 1'b1; rom_full_s = {bank_r, A[14:0]}; end
        MAPPER_ROM128K_RAM4K: begin
          if ((bank_r == 2'd3) && (A[14:12] == 3'b111)) begin
            ram_hit_s  = 1'b1;
            ram_full_s = {1'b0, A[11:0]};
          end else begin
            rom_hit_s  = 1'b1;
            rom_full_s = {bank_r, A[14:0]};
          end
        end
        default: begin
          rom_hit_s = 1'b0;
          ram_hit_s = 1'b0;
        end
      endcase
    end else begin
      rom_hit_s = 1'b0;
      ram_hit_s = 1'b0;
    end
  end

  // Fit the native 17/13-bit addresses to the configured port widths.
  generate
    if (ROM_AW > 17) begin : g_rom_wide
      assign rom_a_d_s = {{(ROM_AW-17){1'b0}}, rom_full_s};
    end else if (ROM_AW == 17) begin : g_rom_exact
      assign rom_a_d_s = rom_full_s;
    end else begin : g_rom_narrow
      assign rom_a_d_s = rom_full_s[ROM_AW-1:0];
    end
    if (RAM_AW > 13) begin : g_ram_wide
      assign ram_a_d_s = {{(RAM_AW-13){1'b0}}, ram_full_s};
    end else if (RAM_AW == 13) begin : g_ram_exact
      assign ram_a_d_s = ram_full_s;
    end else begin : g_ram_narrow
      assign ram_a_d_s = ram_full_s[RAM_AW-1:0];
    end
  endgenerate

  // Output registers; strobes are gated by next READY so they never show while READY is low.
  always_ff @(posedge CLK) begin
    if (RES) begin
      rom_a_r      <= '0;
      ram_a_r      <= '0;
      rom_ce_r     <= 1'b0;
      ram_ce_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ready_r      <= 1'b0;
      mapper_act_r <= MAPPER_ROM32K;
    end else begin
      rom_a_r      <= rom_a_d_s;
      ram_a_r      <= ram_a_d_s;
      rom_ce_r     <= ready_d_s & RD & rom_hit_s;
      ram_ce_r     <= ready_d_s & (RD | WR) & ram_hit_s;
      ram_we_r     <= ready_d_s & WR & ram_hit_s;
      ready_r      <= ready_d_s;
      mapper_act_r <= act_d_s;
    end
  end

  assign ROM_A      = rom_a_r;
  assign RAM_A      = ram_a_r;
  assign ROM_CE     = rom_ce_r;
  assign RAM_CE     = ram_ce_r;
  assign RAM_WE     = ram_we_r;
  assign READY      = ready_r;
  assign MAPPER_ACT = mapper_act_r;

endmodule

// File: doc/scv_cart_mapper.md
# scv_cart_mapper

Cartridge memory mapper for the Super Cassette Vision core: translates CPU cartridge-space accesses (0x8000–0xFFFF) into cartridge ROM/RAM addresses and strobes for every `mapper_t` type. It sits between the CPU bus and the SDRAM/BRAM cartridge store. It owns the bank register and auto-detects the mapper from ROM image size during download when `MAPPER_AUTO` is selected.

## Interface
Parameters:
- `ROM_AW`, 17, ROM byte-address width; 17 covers 128 KB, and smaller values truncate the high bits.
- `RAM_AW`, 13, cartridge RAM byte-address width; 13 covers 8 KB.

Ports:
- `CLK` in 1: system clock. One clock domain.
- `RES` in 1: reset, synchronous, active-high.
- `CE` in 1: CPU clock enable; gates bank-register writes.
- `MAPPER_SEL` in `mapper_t`: user/OSD mapper choice; `MAPPER_AUTO` enables detection.
- `LOAD_ACTIVE` in 1: ROM download in progress.
- `LOAD_WR` in 1: download byte strobe.
- `LOAD_ADDR` in `ROM_AW`: download byte address.
- `A` in 16: CPU address.
- `RD` in 1: CPU read strobe.
- `WR` in 1: CPU write strobe.
- `BANK_WR` in 1: CPU port-C write qualifier.
- `BANK_IN` in 2: port-C bits PC6:PC5.
- `ROM_A` out `ROM_AW`: ROM byte address.
- `ROM_CE` out 1: ROM select.
- `RAM_A` out `RAM_AW`: RAM byte address.
- `RAM_CE` out 1: RAM select.
- `RAM_WE` out 1: RAM write.
- `MAPPER_ACT` out `mapper_t`: mapper in effect.
- `READY` out 1: mapping valid; the CPU may be released.

## Operation
- FSM states: IDLE, LOADING, CLASSIFY, RUN.
- IDLE → LOADING when `LOAD_ACTIVE`=1. IDLE → RUN when `LOAD_ACTIVE`=0 and `MAPPER_SEL`≠AUTO.
- LOADING: `max_addr` clears on entry. Each `LOAD_WR` sets `max_addr` to max(`max_addr`, `LOAD_ADDR`).
- LOADING → CLASSIFY on `LOAD_ACTIVE` falling.
- CLASSIFY lasts 1 cycle and computes size = `max_addr`+1 at `ROM_AW`+1 bits so no wrap at full size.
- AUTO classification:
  - ≤8K → ROM8K
  - ≤16K → ROM16K
  - ≤32K → ROM32K
  - ≤64K → ROM64K
  - otherwise → ROM128K
  - RAM variants are never auto-detected and require explicit selection.
- CLASSIFY → RUN.
- RUN: `MAPPER_ACT` = `MAPPER_SEL` if ≠AUTO, else the detected value. `LOAD_ACTIVE`=1 returns the FSM to LOADING.
- `MAPPER_SEL` changes take effect in RUN on the next cycle; the detected value is retained.
- Bank register `bank[1:0]` loads from `BANK_IN` when `CE & BANK_WR`. Its value is irrelevant for non-banked mappers.
- Decode applies only when A15=1. A15=0 gives no strobes.
  - ROM8K: ROM at A[12:0], mirrored.
  - ROM16K: ROM at A[13:0], mirrored.
  - ROM32K: ROM at A[14:0].
  - ROM32K_RAM8K: 0xE000–0xFFFF → RAM at A[12:0]; the rest → ROM at A[14:0].
  - ROM64K: ROM at {bank[0], A[14:0]}.
  - ROM128K: ROM at {bank, A[14:0]}.
  - ROM128K_RAM4K: when bank=3, 0xF000–0xFFFF → RAM at A[11:0]. All other accesses → ROM at {bank, A[14:0]}.
- Strobes:
  - `ROM_CE` = `RD` & ROM-hit. Writes to ROM are ignored.
  - `RAM_CE` = (`RD`|`WR`) & RAM-hit.
  - `RAM_WE` = `WR` & RAM-hit.
- Address truncation: addresses are truncated to `ROM_AW`/`RAM_AW`. Unused high bits are zero-extended when the port is wider than needed.

## Timing
- Reset values:
  - FSM IDLE, `max_addr`=0, `bank`=0, `MAPPER_ACT`=ROM32K.
  - `READY`=0, all strobes 0, `ROM_A`=0, `RAM_A`=0.
- Decode outputs are registered: 1 CLK latency from `A`/`RD`/`WR`/`bank` to `ROM_*`/`RAM_*`.
- A bank write on cycle n affects decode of addresses presented at n+1. The output appears at n+2.
- `READY` is high only in RUN. It drops the cycle after `LOAD_ACTIVE` rises.
- `MAPPER_ACT` and `READY`=1 are valid the cycle after CLASSIFY, i.e. 2 cycles after `LOAD_ACTIVE` falls.
- Boundary conditions:
  - `LOAD_WR` on the same cycle `LOAD_ACTIVE` falls: the byte counts toward size.
  - `RES` during LOADING aborts to IDLE; detection restarts on the next load.
  - No `LOAD_WR` during a load: size 1 → ROM8K.
  - All strobes are forced 0 while `READY`=0.

## Structure
- Add to `scv_pkg`:
  - `cart_state_t` enum (IDLE/LOADING/CLASSIFY/RUN).
  - Size threshold constants `CART_8K`…`CART_64K`.
  - A `mapper_from_size()` function.
- One sub-module, `scv_cart_size_detect`: the `max_addr` tracker and classifier. It outputs detected `mapper_t` and a done pulse.
- The decode is a single combinational block feeding output registers.

## Test plan
- Reset, then sample outputs → `READY`=0, `MAPPER_ACT`=ROM32K, strobes 0, `bank`=0.
- AUTO, load bytes 0..0x3FFF, drop `LOAD_ACTIVE` → after 2 CLK `MAPPER_ACT`=ROM16K, `READY`=1. RD A=0xC123 → `ROM_A`=0x0123, `ROM_CE`=1.
- AUTO, last `LOAD_ADDR`=0x1FFFF written on the falling cycle → ROM128K. `BANK_IN`=2 with `CE`&`BANK_WR`, then RD A=0x8004 → `ROM_A`=0x10004.
- `MAPPER_SEL`=ROM32K_RAM8K, WR A=0xE010 → `RAM_A`=0x0010, `RAM_WE`=1, `ROM_CE`=0. RD A=0xDFFF → `ROM_A`=0x5FFF.
- ROM128K_RAM4K: bank=3, RD A=0xF001 → `RAM_CE`=1, `RAM_A`=0x001. Bank=1, RD A=0xF001 → `ROM_A`=0x0F001.
- `RES` asserted mid-load after writes to 0xFFFF, then a new load to 0x1FFF → ROM8K, not ROM64K.
